// File: rtl/shared_mem_pkg.sv
// -----------------------------------------------------------------------------
// shared_mem_pkg
// Shared definitions for the instruction/data shared-memory arbiter:
//   - default parameter values for shared_mem_arbiter
//   - byte offsets of the IO registers relative to the IO base address
//   - the response-source enum used to steer read data one cycle after grant
//   - a small address-decode helper
// -----------------------------------------------------------------------------
package shared_mem_pkg;

    localparam int          DATA_W_DEF     = 32;
    localparam int          DEPTH_DEF      = 1024;
    localparam int          N_SW_DEF       = 10;
    localparam int          N_LED_DEF      = 10;
    localparam logic [31:0] IO_BASE_DEF    = 32'hC000_0000;
    localparam int          STARVE_MAX_DEF = 4;

    // IO register offsets from IO_BASE
    localparam logic [31:0] LED_OFS = 32'h0000_0000;
    localparam logic [31:0] SW_OFS  = 32'h0000_0004;

    // Where the read data of a granted access comes from in the next cycle
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_RAM  = 2'd1,
        RSP_IO   = 2'd2
    } rsp_src_e;

    // Everything at or above the IO base is memory-mapped IO
    function automatic logic is_io(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for asynchronous level inputs (e.g. board switches).
// Ports:
//   clk    in   1  destination clock
//   reset  in   1  asynchronous, active-high; clears both flop stages
//   d_i    in   W  asynchronous input
//   q_o    out  W  synchronised output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two cascaded stages; the first may go metastable, the second is used
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter
// Arbitrates an instruction-fetch port and a data port onto one single-port
// synchronous RAM plus a tiny IO region (LED register, synchronised switches).
// Data wins by default; fetch is forced through after STARVE_MAX consecutive
// denials. Every granted access answers exactly one cycle later.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   if_req/if_addr             fetch request and byte address
//   if_gnt                     fetch granted this cycle (combinational)
//   if_valid/if_rdata          fetch response, one cycle after grant
//   d_req/d_we/d_addr/d_wdata  data request, write enable, address, data
//   d_gnt                      data granted this cycle (combinational)
//   d_valid/d_rdata            data response (read data, or 0 for write ack)
//   switches                   asynchronous switch inputs
//   leds                       LED register
// -----------------------------------------------------------------------------
module shared_mem_arbiter
    import shared_mem_pkg::*;
#(
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int          DEPTH      = DEPTH_DEF,
    parameter int          N_SW       = N_SW_DEF,
    parameter int          N_LED      = N_LED_DEF,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEF,
    parameter int          STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic [N_SW-1:0]   switches,
    output logic [N_LED-1:0]  leds
);

    localparam int             AW         = $clog2(DEPTH);
    localparam int             CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]  STARVE_LIM = CW'(STARVE_MAX);

    // Arbitration
    logic              force_if_s;
    logic              if_gnt_s;
    logic              d_gnt_s;
    logic [CW-1:0]     starve_q;
    logic [CW-1:0]     starve_d;

    // Access decode
    logic [31:0]       acc_addr_s;
    logic              acc_io_s;
    logic [31:0]       io_ofs_s;
    logic [AW-1:0]     ram_idx_s;
    logic              ram_we_s;
    logic              ram_re_s;
    logic              led_we_s;
    logic [DATA_W-1:0] io_rd_s;
    rsp_src_e          rsp_src_d;

    // Response state
    logic              if_valid_q;
    logic              d_valid_q;
    rsp_src_e          rsp_src_q;
    logic [DATA_W-1:0] io_rdata_q;
    logic [DATA_W-1:0] ram_rdata_q;
    logic [DATA_W-1:0] rdata_s;
    logic [N_LED-1:0]  leds_q;
    logic [N_SW-1:0]   sw_sync_s;

    logic [DATA_W-1:0] mem_q [DEPTH];

    sync_2ff #(
        .W (N_SW)
    ) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (switches),
        .q_o   (sw_sync_s)
    );

    // Grant selection: data first unless fetch has been starved long enough
    always_comb begin
        force_if_s = (starve_q == STARVE_LIM) && if_req;
        d_gnt_s    = d_req && !force_if_s;
        if_gnt_s   = if_req && !d_gnt_s;
    end

    // Starve counter: counts consecutive denied fetch cycles, saturating
    always_comb begin
        if (if_req && !if_gnt_s) begin
            if (starve_q == STARVE_LIM) begin
                starve_d = starve_q;
            end else begin
                starve_d = starve_q + CW'(1);
            end
        end else begin
            starve_d = '0;
        end
    end

    // Decode the single granted access (the address mux follows the grant)
    always_comb begin
        acc_addr_s = d_gnt_s ? d_addr : if_addr;
        acc_io_s   = is_io(acc_addr_s, IO_BASE);
        io_ofs_s   = acc_addr_s - IO_BASE;
        ram_idx_s  = acc_addr_s[AW+1:2];
        // A write landing on the reset edge is dropped rather than half-done
        ram_we_s   = d_gnt_s && d_we && !acc_io_s && !reset;
        ram_re_s   = ((d_gnt_s && !d_we) || if_gnt_s) && !acc_io_s;
        led_we_s   = d_gnt_s && d_we && acc_io_s && (io_ofs_s == LED_OFS);

        if (d_gnt_s && !d_we && acc_io_s) begin
            if (io_ofs_s == LED_OFS) begin
                io_rd_s = DATA_W'(leds_q);
            end else if (io_ofs_s == SW_OFS) begin
                io_rd_s = DATA_W'(sw_sync_s);
            end else begin
                io_rd_s = '0;
            end
        end else begin
            io_rd_s = '0;
        end

        // Fetches from IO and all write acks return zero via RSP_NONE
        if (ram_re_s) begin
            rsp_src_d = RSP_RAM;
        end else if (d_gnt_s && !d_we && acc_io_s) begin
            rsp_src_d = RSP_IO;
        end else begin
            rsp_src_d = RSP_NONE;
        end
    end

    // Control/response registers and the LED register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q   <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            rsp_src_q  <= RSP_NONE;
            io_rdata_q <= '0;
            leds_q     <= '0;
        end else begin
            starve_q   <= starve_d;
            if_valid_q <= if_gnt_s;
            d_valid_q  <= d_gnt_s;
            rsp_src_q  <= rsp_src_d;
            io_rdata_q <= io_rd_s;
            if (led_we_s) begin
                leds_q <= d_wdata[N_LED-1:0];
            end
        end
    end

    // Single-port RAM with registered read; no reset so it maps to block RAM
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_q[ram_idx_s] <= d_wdata;
        end
        if (ram_re_s) begin
            ram_rdata_q <= mem_q[ram_idx_s];
        end
    end

    // Response data steering; the valid flags keep the idle port at zero
    always_comb begin
        case (rsp_src_q)
            RSP_RAM: rdata_s = ram_rdata_q;
            RSP_IO:  rdata_s = io_rdata_q;
            default: rdata_s = '0;
        endcase
    end

    assign if_gnt   = if_gnt_s;
    assign d_gnt    = d_gnt_s;
    assign if_valid = if_valid_q;
    assign d_valid  = d_valid_q;
    assign if_rdata = if_valid_q ? rdata_s : '0;
    assign d_rdata  = d_valid_q ? rdata_s : '0;
    assign leds     = leds_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_mem_arbiter
// Directed stimulus with a behavioural reference model (associative memory,
// integer starve count, switch sample history) compared on every negedge,
// plus hand-computed literal checks at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_shared_mem_arbiter;

    localparam int          DATA_W     = 32;
    localparam int          DEPTH      = 1024;
    localparam int          N_SW       = 10;
    localparam int          N_LED      = 10;
    localparam logic [31:0] IO_BASE    = 32'hC000_0000;
    localparam int          STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic [N_SW-1:0]   switches;
    logic [N_LED-1:0]  leds;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    shared_mem_arbiter #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .N_SW       (N_SW),
        .N_LED      (N_LED),
        .IO_BASE    (IO_BASE),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_valid  (d_valid),
        .d_rdata  (d_rdata),
        .switches (switches),
        .leds     (leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0]      mem_m [int];
    int               starve_m   = 0;
    logic [N_LED-1:0] leds_m     = '0;
    logic [N_SW-1:0]  samp_last  = '0;  // switches seen at the latest edge
    logic [N_SW-1:0]  samp_prev  = '0;  // switches seen one edge before that
    bit               e_if_v     = 1'b0;
    bit               e_d_v      = 1'b0;
    logic [31:0]      e_if_r     = '0;
    logic [31:0]      e_d_r      = '0;
    bit               e_if_known = 1'b1;
    bit               e_d_known  = 1'b1;

    initial begin
        forever begin
            bit          g_i, g_d, n_if_v, n_d_v, n_if_k, n_d_k;
            logic [31:0] n_if_r, n_d_r, ofs;
            logic [N_LED-1:0] leds_next;
            int          k;
            @(negedge clk);
            if (reset) begin
                starve_m = 0; leds_m = '0; samp_last = '0; samp_prev = '0;
                e_if_v = 1'b0; e_d_v = 1'b0; e_if_r = '0; e_d_r = '0;
                e_if_known = 1'b1; e_d_known = 1'b1;
            end
            g_d = d_req && !((starve_m == STARVE_MAX) && if_req);
            g_i = if_req && !g_d;
            if (chk_en) begin
                chk("if_gnt", 32'(if_gnt), 32'(g_i));
                chk("d_gnt", 32'(d_gnt), 32'(g_d));
                chk("if_valid", 32'(if_valid), 32'(e_if_v));
                chk("d_valid", 32'(d_valid), 32'(e_d_v));
                if (e_if_known) chk("if_rdata", if_rdata, e_if_r);
                if (e_d_known) chk("d_rdata", d_rdata, e_d_r);
                chk("leds", 32'(leds), 32'(leds_m));
            end
            // predict the effect of the coming rising edge
            n_if_v = 1'b0; n_d_v = 1'b0; n_if_r = '0; n_d_r = '0;
            n_if_k = 1'b1; n_d_k = 1'b1; leds_next = leds_m;
            if (!reset) begin
                if (g_i) begin
                    n_if_v = 1'b1;
                    if (if_addr < IO_BASE) begin
                        k = int'((if_addr >> 2) % DEPTH);
                        if (mem_m.exists(k)) n_if_r = mem_m[k];
                        else n_if_k = 1'b0;
                    end
                end
                if (g_d) begin
                    n_d_v = 1'b1;
                    k     = int'((d_addr >> 2) % DEPTH);
                    ofs   = d_addr - IO_BASE;
                    if (d_we) begin
                        if (d_addr >= IO_BASE) begin
                            if (ofs == 32'd0) leds_next = d_wdata[N_LED-1:0];
                        end else begin
                            mem_m[k] = d_wdata;
                        end
                    end else if (d_addr >= IO_BASE) begin
                        if (ofs == 32'd0) n_d_r = 32'(leds_m);
                        else if (ofs == 32'd4) n_d_r = 32'(samp_prev);
                        else n_d_r = 32'd0;
                    end else if (mem_m.exists(k)) begin
                        n_d_r = mem_m[k];
                    end else begin
                        n_d_k = 1'b0;
                    end
                end
                if (if_req && !g_i) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
                else starve_m = 0;
                samp_prev = samp_last;
                samp_last = switches;
                leds_m    = leds_next;
            end
            e_if_v = n_if_v; e_d_v = n_d_v; e_if_r = n_if_r; e_d_r = n_d_r;
            e_if_known = n_if_k; e_d_known = n_d_k;
        end
    end

    // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
    task automatic idle();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a data request and hold it until granted; leaves it asserted
    task automatic d_op(input logic we, input logic [31:0] a, input logic [31:0] wd);
        bit done = 1'b0;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        for (int i = 0; i < 20 && !done; i++) begin
            #2;
            if (d_gnt === 1'b1) done = 1'b1;
            next_cycle();
        end
        if (!done) chk("d_grant_timeout", 32'd0, 32'd1);
    endtask

    logic [9:0] dpat, ipat, vpat;

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; switches = '0;
        next_cycle();
        chk_en = 1'b1;
        #2;
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        next_cycle();
        reset = 1'b0;

        // write then back-to-back read of the same word
        d_op(1'b1, 32'h10, 32'hDEAD_BEEF);
        d_we = 1'b0;
        #2;
        chk("wr_ack_valid", 32'(d_valid), 32'd1);
        chk("wr_ack_rdata", d_rdata, 32'd0);
        next_cycle();
        idle();
        #2;
        chk("rd_after_wr", d_rdata, 32'hDEAD_BEEF);
        next_cycle();

        // byte offset within a word is ignored
        d_op(1'b0, 32'h13, 32'd0);
        idle();
        #2;
        chk("rd_unaligned", d_rdata, 32'hDEAD_BEEF);
        next_cycle();

        // LED write, then switches through the synchroniser
        d_op(1'b1, IO_BASE, 32'h0000_03FF);
        idle();
        #2;
        chk("led_write", 32'(leds), 32'h3FF);
        next_cycle();
        switches = 10'h155;
        repeat (3) next_cycle();
        d_op(1'b0, IO_BASE + 32'd4, 32'd0);
        idle();
        #2;
        chk("sw_read", d_rdata, 32'h155);
        next_cycle();
        d_op(1'b1, IO_BASE + 32'd4, 32'hFFFF_FFFF);   // read-only, ignored
        d_op(1'b0, IO_BASE + 32'd8, 32'd0);           // unmapped, reads 0
        d_op(1'b0, IO_BASE, 32'd0);
        idle();
        #2;
        chk("led_readback", d_rdata, 32'h3FF);
        next_cycle();
        switches = 10'h2AA;                            // read right away sees old value
        d_op(1'b0, IO_BASE + 32'd4, 32'd0);
        idle();
        next_cycle();

        // address wrap and IO fetch
        d_op(1'b1, 32'h0, 32'h0000_1234);
        d_op(1'b0, DEPTH * 4, 32'd0);
        idle();
        #2;
        chk("wrap_read", d_rdata, 32'h1234);
        next_cycle();
        if_req = 1'b1; if_addr = IO_BASE;
        #2;
        chk("io_fetch_gnt", 32'(if_gnt), 32'd1);
        next_cycle();
        if_addr = 32'h0;                               // back-to-back fetch from RAM
        #2;
        chk("io_fetch_valid", 32'(if_valid), 32'd1);
        chk("io_fetch_rdata", if_rdata, 32'd0);
        next_cycle();
        idle();
        #2;
        chk("ram_fetch_rdata", if_rdata, 32'h1234);
        next_cycle();

        // contention: fetch forced through after STARVE_MAX denials
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
        for (int c = 0; c < 10; c++) begin
            #2;
            dpat[c] = d_gnt; ipat[c] = if_gnt; vpat[c] = if_valid;
            next_cycle();
        end
        idle();
        chk("starve_dpat", 32'(dpat), 32'h1EF);   // 10'b01_1110_1111
        chk("starve_ipat", 32'(ipat), 32'h210);   // 10'b10_0001_0000
        chk("starve_vpat", 32'(vpat), 32'h020);   // if_valid one cycle after each fetch grant
        next_cycle();

        // reset during a granted read
        d_op(1'b1, IO_BASE, 32'h0000_00AA);
        idle();
        #2;
        chk("led_0aa", 32'(leds), 32'h0AA);
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; reset = 1'b1;
        #2;
        chk("rst_clears_leds", 32'(leds), 32'd0);
        next_cycle();
        #2;
        chk("rst_no_valid", 32'(d_valid), 32'd0);
        next_cycle();
        reset = 1'b0;
        #2;
        chk("first_gnt_after_rst", 32'(d_gnt), 32'd1);
        next_cycle();
        idle();
        #2;
        chk("post_rst_valid", 32'(d_valid), 32'd1);
        chk("ram_kept_over_rst", d_rdata, 32'hDEAD_BEEF);
        next_cycle();
        repeat (2) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
